// File: rtl/discrete_cell_checker_if.sv
// rtl/discrete_cell_checker_if.sv - controller-side handshake and result bundle for discrete_cell_checker
interface discrete_cell_checker_if #(
   parameter int ERR_W = 8
);
   logic             start;
   logic [3:0]       cell_sel;
   logic             busy;
   logic             done;
   logic             pass;
   logic [3:0]       fail_vec;
   logic [ERR_W-1:0] err_count;

   // board-test controller side
   modport master (
      output start, cell_sel,
      input  busy, done, pass, fail_vec, err_count
   );

   // checker side
   modport slave (
      input  start, cell_sel,
      output busy, done, pass, fail_vec, err_count
   );
endinterface

// File: rtl/discrete_cell_checker.sv
// rtl/discrete_cell_checker.sv - drives a discrete-FET cell through its four input vectors and checks Y
module discrete_cell_checker #(
   parameter int SETTLE_CYCLES = 16,
   parameter int ERR_W         = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   discrete_cell_checker_if.slave ctl,
   output logic                  dut_a,
   output logic                  dut_b,
   input  logic                  dut_y
);

   localparam logic [15:0]      SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX     = '1;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      SAMPLE,
      FINISH
   } state_t;

   state_t           state;
   logic [3:0]       sel_q;
   logic [1:0]       vi;
   logic [15:0]      settle_cnt;
   logic [3:0]       fail_vec_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [ERR_W-1:0] err_count_q;
   logic             y_s1;
   logic             y_s2;
   logic             mismatch;
   logic [3:0]       final_fv;

   // Expected Y for each supported cell type; unused codes never reach SAMPLE.
   function automatic logic expected_y(input logic [3:0] sel, input logic a, input logic b);
      case (sel)
         4'd0:    expected_y = ~a;
         4'd1:    expected_y = a;
         4'd2:    expected_y = ~(a & b);
         4'd3:    expected_y = a & b;
         4'd4:    expected_y = a & ~b;
         4'd5:    expected_y = a | b;
         4'd6:    expected_y = ~(a | b);
         4'd7:    expected_y = a | ~b;
         4'd8:    expected_y = a ^ b;
         4'd9:    expected_y = ~(a ^ b);
         default: expected_y = 1'b0;
      endcase
   endfunction

   // Y is asynchronous to clk, so it only enters the compare through two flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_s1 <= 1'b0;
         y_s2 <= 1'b0;
      end else begin
         y_s1 <= dut_y;
         y_s2 <= y_s1;
      end
   end

   // Failure mask as it stands once the current cycle's compare is folded in.
   always_comb begin
      mismatch = 1'b0;
      final_fv = fail_vec_q;
      if (state == SAMPLE) begin
         mismatch = (y_s2 != expected_y(sel_q, vi[1], vi[0]));
         final_fv = fail_vec_q | (4'(mismatch) << vi);
      end
   end

   // Run sequencer: walks vectors 00..11, then publishes done/pass/err_count together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         sel_q       <= 4'd0;
         vi          <= 2'd0;
         settle_cnt  <= 16'd0;
         fail_vec_q  <= 4'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_count_q <= '0;
         dut_a       <= 1'b0;
         dut_b       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ctl.start) begin
                  sel_q  <= ctl.cell_sel;
                  vi     <= 2'd0;
                  busy_q <= 1'b1;
                  if (ctl.cell_sel <= 4'd9) begin
                     fail_vec_q <= 4'd0;
                     state      <= DRIVE;
                  end else begin
                     fail_vec_q <= 4'hF;
                     state      <= FINISH;
                  end
               end
            end
            DRIVE: begin
               dut_a      <= vi[1];
               dut_b      <= vi[0];
               settle_cnt <= SETTLE_LOAD;
               state      <= SETTLE;
            end
            SETTLE: begin
               if (settle_cnt == 16'd0) begin
                  state <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt - 16'd1;
               end
            end
            SAMPLE: begin
               fail_vec_q <= final_fv;
               if (vi == 2'd3) begin
                  // Result is published on entry so done is high for the whole FINISH cycle.
                  done_q <= 1'b1;
                  pass_q <= (final_fv == 4'd0);
                  if (final_fv != 4'd0 && err_count_q != ERR_MAX) begin
                     err_count_q <= err_count_q + 1'b1;
                  end
                  state <= FINISH;
               end else begin
                  vi    <= vi + 2'd1;
                  state <= DRIVE;
               end
            end
            FINISH: begin
               if (!done_q) begin
                  // An invalid select arrives here straight from IDLE without a result
                  // published yet, so it spends one extra cycle raising done.
                  done_q <= 1'b1;
                  pass_q <= (final_fv == 4'd0);
                  if (final_fv != 4'd0 && err_count_q != ERR_MAX) begin
                     err_count_q <= err_count_q + 1'b1;
                  end
               end else begin
                  done_q <= 1'b0;
                  busy_q <= 1'b0;
                  dut_a  <= 1'b0;
                  dut_b  <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ctl.busy      = busy_q;
   assign ctl.done      = done_q;
   assign ctl.pass      = pass_q;
   assign ctl.fail_vec  = fail_vec_q;
   assign ctl.err_count = err_count_q;

endmodule

// File: tb/tb_discrete_cell_checker.sv
// tb/tb_discrete_cell_checker.sv - self-checking bench for discrete_cell_checker
module tb_discrete_cell_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       a0, b0, y0, a1, b1, y1;
   logic [3:0] msel0 = 4'd0, mmask0 = 4'd0, msel1 = 4'd0, mmask1 = 4'd0;

   int checks = 0;
   int errors = 0;

   discrete_cell_checker_if #(.ERR_W(8)) if0 ();
   discrete_cell_checker_if #(.ERR_W(2)) if1 ();

   discrete_cell_checker #(.SETTLE_CYCLES(16), .ERR_W(8)) u0 (
      .clk   (clk),
      .rst   (rst),
      .ctl   (if0),
      .dut_a (a0),
      .dut_b (b0),
      .dut_y (y0)
   );

   discrete_cell_checker #(.SETTLE_CYCLES(3), .ERR_W(2)) u1 (
      .clk   (clk),
      .rst   (rst),
      .ctl   (if1),
      .dut_a (a1),
      .dut_b (b1),
      .dut_y (y1)
   );

   // Truth table per cell, bit index = {a,b}.
   function automatic logic [3:0] truth_table(input logic [3:0] sel);
      case (sel)
         4'd0:    truth_table = 4'b0011;
         4'd1:    truth_table = 4'b1100;
         4'd2:    truth_table = 4'b0111;
         4'd3:    truth_table = 4'b1000;
         4'd4:    truth_table = 4'b0100;
         4'd5:    truth_table = 4'b1110;
         4'd6:    truth_table = 4'b0001;
         4'd7:    truth_table = 4'b1101;
         4'd8:    truth_table = 4'b0110;
         4'd9:    truth_table = 4'b1001;
         default: truth_table = 4'b0000;
      endcase
   endfunction

   // Cell model: ideal output with the vectors in mask flipped.
   function automatic logic cell_out(input logic [3:0] sel, input logic [3:0] mask,
                                     input logic a, input logic b);
      logic [3:0] t;
      t = truth_table(sel) ^ mask;
      return t[{a, b}];
   endfunction

   assign y0 = cell_out(msel0, mmask0, a0, b0);
   assign y1 = cell_out(msel1, mmask1, a1, b1);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic peek(input int which, output logic bz, output logic dn, output logic [1:0] pins,
                       output logic [3:0] fv, output logic ps, output int ec);
      if (which == 0) begin
         bz = if0.busy; dn = if0.done; pins = {a0, b0};
         fv = if0.fail_vec; ps = if0.pass; ec = int'(if0.err_count);
      end else begin
         bz = if1.busy; dn = if1.done; pins = {a1, b1};
         fv = if1.fail_vec; ps = if1.pass; ec = int'(if1.err_count);
      end
   endtask

   task automatic set_start(input int which, input logic v);
      if (which == 0) if0.start = v;
      else            if1.start = v;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // One run; lat is cycles from the accepting edge to the done cycle (-1 on timeout).
   task automatic run_dut(input int which, input logic [3:0] sel, input logic [3:0] mask,
                          input bit hold, input int pulse_k, input string tag,
                          output int lat, output logic [3:0] fv, output logic ps, output int ec);
      int         per;
      bit         valid;
      int         bad_pins, bad_busy;
      logic [1:0] pins, exp_pins;
      logic       bz, dn;
      logic [3:0] fvx;
      logic       psx;
      int         ecx;
      bit         seen;
      per      = (which == 0) ? 18 : 5;
      valid    = (sel < 4'd10);
      lat      = -1;
      fv       = 4'hx;
      ps       = 1'bx;
      ec       = -1;
      bad_pins = 0;
      bad_busy = 0;
      if (which == 0) begin msel0 = sel; mmask0 = mask; if0.cell_sel = sel; end
      else            begin msel1 = sel; mmask1 = mask; if1.cell_sel = sel; end
      set_start(which, 1'b1);
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         peek(which, bz, dn, pins, fvx, psx, ecx);
         exp_pins = (valid && k >= 2 && k < 2 + 4 * per) ? 2'((k - 2) / per) : 2'b00;
         if (pins !== exp_pins) bad_pins++;
         if (bz !== 1'b1) bad_busy++;
         if (dn === 1'b1) begin
            lat = k; fv = fvx; ps = psx; ec = ecx;
            break;
         end
         set_start(which, hold || (pulse_k != 0 && k == pulse_k));
      end
      check({tag, "_pin_trace"}, bad_pins, 0);
      check({tag, "_busy_trace"}, bad_busy, 0);
      @(posedge clk); #1;
      peek(which, bz, dn, pins, fvx, psx, ecx);
      check({tag, "_busy_after_done"}, bz, 0);
      check({tag, "_done_single"}, dn, 0);
      check({tag, "_pins_idle"}, pins, 0);
      if (hold) begin
         @(posedge clk); #1;
         peek(which, bz, dn, pins, fvx, psx, ecx);
         check({tag, "_held_restart"}, bz, 1);
         set_start(which, 1'b0);
         seen = 0;
         for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk); #1;
            peek(which, bz, dn, pins, fvx, psx, ecx);
            if (dn === 1'b1) seen = 1;
         end
         check({tag, "_held_second_done"}, seen, 1);
         @(posedge clk); #1;
      end
   endtask

   typedef struct {
      bit         reset_before;
      logic [3:0] sel;
      logic [3:0] mask;
      int         pulse_k;
      int         lat;
      logic [3:0] fv;
      bit         ps;
      int         ec;
   } vec_t;

   vec_t tbl [8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int         lat, ec, err_m, exp_lat;
      logic [3:0] fv, exp_fv, sel, mask;
      logic       ps, bz, dn;
      logic [1:0] pins;
      bit         exp_ps, seen_done;

      tbl[0] = '{0, 4'd2,  4'b0000, 0,  73, 4'b0000, 1, 0};
      tbl[1] = '{0, 4'd8,  4'b0110, 0,  73, 4'b0110, 0, 1};
      tbl[2] = '{1, 4'd9,  4'b0110, 0,  73, 4'b0110, 0, 1};
      tbl[3] = '{0, 4'd4,  4'b0000, 0,  73, 4'b0000, 1, 1};
      tbl[4] = '{0, 4'd12, 4'b0000, 0,  2,  4'b1111, 0, 2};
      tbl[5] = '{0, 4'd2,  4'b0000, 30, 73, 4'b0000, 1, 2};
      tbl[6] = '{0, 4'd7,  4'b0010, 0,  73, 4'b0010, 0, 3};
      tbl[7] = '{0, 4'd0,  4'b1000, 0,  73, 4'b1000, 0, 4};

      rst = 1'b1;
      if0.start = 1'b0; if0.cell_sel = 4'd0;
      if1.start = 1'b0; if1.cell_sel = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;

      peek(0, bz, dn, pins, fv, ps, ec);
      check("reset_busy", bz, 0);
      check("reset_done", dn, 0);
      check("reset_pass", ps, 0);
      check("reset_pins", pins, 0);
      check("reset_fail_vec", fv, 0);
      check("reset_err_count", ec, 0);

      for (int i = 0; i < 8; i++) begin
         if (tbl[i].reset_before) do_reset();
         run_dut(0, tbl[i].sel, tbl[i].mask, 0, tbl[i].pulse_k, $sformatf("row%0d", i),
                 lat, fv, ps, ec);
         check($sformatf("row%0d_latency", i), lat, tbl[i].lat);
         check($sformatf("row%0d_fail_vec", i), fv, tbl[i].fv);
         check($sformatf("row%0d_pass", i), ps, tbl[i].ps);
         check($sformatf("row%0d_err_count", i), ec, tbl[i].ec);
      end

      // start held high across done: ignored in FINISH, accepted in the next IDLE
      run_dut(0, 4'd1, 4'b0000, 1, 0, "held", lat, fv, ps, ec);
      check("held_latency", lat, 73);
      check("held_pass", ps, 1);

      // asynchronous reset during SETTLE of vector 2
      msel0 = 4'd8; mmask0 = 4'b0110; if0.cell_sel = 4'd8; if0.start = 1'b1;
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk); #1;
         if0.start = 1'b0;
      end
      check("midrst_pins_before", {a0, b0}, 2'b10);
      #2;
      rst = 1'b1;
      #1;
      peek(0, bz, dn, pins, fv, ps, ec);
      check("midrst_busy", bz, 0);
      check("midrst_pins", pins, 0);
      check("midrst_err_count", ec, 0);
      check("midrst_fail_vec", fv, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen_done = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (if0.done === 1'b1 || if0.busy === 1'b1) seen_done = 1;
      end
      check("midrst_no_done", seen_done, 0);
      run_dut(0, 4'd0, 4'b0000, 0, 0, "post_rst_not", lat, fv, ps, ec);
      check("post_rst_latency", lat, 73);
      check("post_rst_pass", ps, 1);
      check("post_rst_err_count", ec, 0);

      // randomized runs against the truth-table model
      err_m = 0;
      for (int i = 0; i < 20; i++) begin
         sel  = 4'($urandom_range(0, 15));
         mask = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         exp_fv  = (sel < 4'd10) ? mask : 4'hF;
         exp_ps  = (exp_fv == 4'd0);
         exp_lat = (sel < 4'd10) ? 1 + 4 * (16 + 2) : 2;
         if (exp_fv != 4'd0 && err_m < 255) err_m++;
         run_dut(0, sel, mask, 0, 0, $sformatf("rand%0d", i), lat, fv, ps, ec);
         check($sformatf("rand%0d_latency", i), lat, exp_lat);
         check($sformatf("rand%0d_fail_vec", i), fv, exp_fv);
         check($sformatf("rand%0d_pass", i), ps, exp_ps);
         check($sformatf("rand%0d_err_count", i), ec, err_m);
      end

      // ERR_W=2 saturation on the short-settle instance
      err_m = 0;
      for (int i = 0; i < 5; i++) begin
         run_dut(1, 4'd8, 4'b0110, 0, 0, $sformatf("sat%0d", i), lat, fv, ps, ec);
         err_m = (err_m < 3) ? err_m + 1 : 3;
         check($sformatf("sat%0d_latency", i), lat, 21);
         check($sformatf("sat%0d_fail_vec", i), fv, 4'b0110);
         check($sformatf("sat%0d_pass", i), ps, 0);
         check($sformatf("sat%0d_err_count", i), ec, err_m);
      end
      run_dut(1, 4'd3, 4'b0000, 0, 0, "sat_ideal", lat, fv, ps, ec);
      check("sat_ideal_pass", ps, 1);
      check("sat_ideal_fail_vec", fv, 0);
      check("sat_ideal_err_count", ec, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/discrete_cell_checker.md
# discrete_cell_checker

Sequencer that exercises one discrete-FET logic cell on the bring-up board and checks its truth table. It drives the cell's A/B pins through all four input vectors, waits a programmable settle time per vector, samples the asynchronous Y pin through a synchronizer, and compares the result against the expected function of the selected cell type. It sits between the board-test controller (start/result) and the DUT cell pins, and closes the loop on the gate-to-FET mapping in hardware.

## Interface

Parameters:

- SETTLE_CYCLES, 16, cycles held after driving a vector before sampling; legal range 3..65535.
- ERR_W, 8, width of the cumulative failed-run counter.

Ports:

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- cell_sel  in  4  cell type, latched on accepted start:
  - 0 NOT (~a), 1 BUF (a), 2 NAND, 3 AND, 4 ANDNOT (a&~b), 5 OR, 6 NOR, 7 ORNOT (a|~b), 8 XOR, 9 XNOR.
  - 10..15 are invalid.
- dut_a  out  1  drive to the cell's A pin.
- dut_b  out  1  drive to the cell's B pin.
- dut_y  in  1  cell's Y pin; asynchronous.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  result of the last run; valid from done until the next accepted start.
- fail_vec  out  4  bit i set if vector i = {a,b} mismatched in the last run.
- err_count  out  ERR_W  count of failed runs since reset; saturates at all-ones.

## Operation

- Reset values:
  - busy=0, done=0, pass=0, dut_a=0, dut_b=0, fail_vec=0, err_count=0.
  - Synchronizer flops=0; FSM=IDLE.
- dut_y passes through a 2-flop synchronizer. Only the synchronized value is compared.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, FINISH.
  - IDLE: start=1 latches cell_sel, clears fail_vec and vector index (vi=0).
    - Valid sel: go to DRIVE.
    - Invalid sel: set fail_vec=4'hF and go to FINISH.
  - DRIVE (1 cycle): {dut_a,dut_b} <= vi; load settle counter with SETTLE_CYCLES-1; go to SETTLE.
  - SETTLE: decrement each cycle; at 0 go to SAMPLE. Total SETTLE_CYCLES cycles.
  - SAMPLE (1 cycle): compare synchronized Y with expected(sel, vi); set fail_vec[vi] on mismatch.
    - vi=3: go to FINISH.
    - Otherwise: vi+1, go to DRIVE.
  - FINISH (1 cycle):
    - done=1.
    - pass = (fail_vec==0) registered the same cycle as done.
    - If the run failed, err_count increments, saturating.
    - dut_a/dut_b return to 0; busy drops; go to IDLE.
- Vector order is fixed: {a,b} = 00, 01, 10, 11.
- NOT and BUF ignore b, but all four vectors are still run.
- dut_a/dut_b change only in DRIVE or FINISH, never during SETTLE/SAMPLE.
- start while busy is ignored, not queued. cell_sel changes during a run have no effect.

## Timing

- Accepted start at cycle T: busy=1 and FSM in DRIVE at T+1; new dut_a/dut_b visible at T+2.
- Per vector: SETTLE_CYCLES+2 cycles (DRIVE + SETTLE + SAMPLE).
- Valid run: done pulses at cycle T+1+4·(SETTLE_CYCLES+2). busy is low the cycle after done.
- Invalid sel: done at T+2, pass=0, no pins toggled.
- Synchronizer latency is 2 cycles. SETTLE_CYCLES≥3 guarantees the sampled Y reflects the current vector.
- start asserted in the same cycle as done (FINISH) is ignored. A start held high is accepted in the following IDLE cycle.
- Asynchronous rst mid-run: all outputs take their reset values immediately. Run is abandoned, no done pulse, err_count cleared.
- err_count at all-ones plus a failed run stays at all-ones. pass/fail_vec still update.

## Test plan

- NAND with an ideal cell model on dut_y, SETTLE_CYCLES=16, start at T:
  - done at T+73, pass=1, fail_vec=0, err_count=0.
  - dut_a/dut_b sequence 00,01,10,11, each held 18 cycles.
- XOR with dut_y stuck at 0: fail_vec=4'b0110, pass=0, err_count=1.
- Two runs in the same setup:
  - XNOR with dut_y stuck at 1: fail_vec=4'b0110, err_count=1.
  - Then ANDNOT with an ideal model: pass=1, fail_vec=0, err_count=1 (unchanged).
- cell_sel=12:
  - done at T+2, pass=0, fail_vec=4'hF, err_count increments.
  - dut_a/dut_b remain 0 throughout.
- start pulsed again mid-run: ignored, done timing unchanged.
- rst asserted during SETTLE of vector 2: busy/dut_a/dut_b/err_count go to 0 immediately; no done. A new NOT run afterwards passes with an ideal model.
- ERR_W=2, five consecutive failing runs: err_count reads 1,2,3,3,3.
